// File: rtl/c_decr_seq_pkg.sv
// Shared definitions for the descending wrapping sequencer (c_decr_seq).
package c_decr_seq_pkg;

  localparam int unsigned STATE_WIDTH = 1;

  typedef enum logic [STATE_WIDTH-1:0] {
    STATE_IDLE = 1'b0,
    STATE_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/c_decr.sv
// Combinational wrapping decrementer over [min_value, max_value]; min_value wraps to max_value.
module c_decr #(
  parameter int width     = 4,
  parameter int min_value = 4,
  parameter int max_value = 7
) (
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out
);

  localparam logic [width-1:0] MIN_V = width'(min_value);
  localparam logic [width-1:0] MAX_V = width'(max_value);
  localparam logic [width-1:0] ONE   = width'(1);

  always_comb begin
    data_out = (data_in == MIN_V) ? MAX_V : data_in - ONE;
  end

endmodule

// File: rtl/c_decr_seq.sv
// Emits a descending, wrapping run of values over a valid/ready handshake.
// Optional start_value range rejection is enabled by defining C_DECR_SEQ_RANGE_CHECK_EN.
module c_decr_seq
  import c_decr_seq_pkg::*;
#(
  parameter int width     = 4,
  parameter int min_value = 4,
  parameter int max_value = 7,
  parameter int len_width = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [width-1:0]     start_value,
  input  logic [len_width-1:0] run_len,
  output logic                 busy,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [width-1:0]     data_out,
  output logic [len_width-1:0] remaining,
  output logic                 done,
  output logic                 error
);

  localparam logic [width-1:0]     MIN_V   = width'(min_value);
  localparam logic [width-1:0]     MAX_V   = width'(max_value);
  localparam logic [len_width-1:0] ONE_LEN = len_width'(1);

`ifdef C_DECR_SEQ_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t               state, state_nxt;
  logic [width-1:0]     value_q, value_nxt, value_dec;
  logic [len_width-1:0] rem_q, rem_nxt;
  logic                 done_q, done_nxt;
  logic                 err_q, err_nxt;
  logic                 in_range, reject, fire;

  c_decr #(
    .width    (width),
    .min_value(min_value),
    .max_value(max_value)
  ) u_decr (
    .data_in (value_q),
    .data_out(value_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= STATE_IDLE;
      value_q <= MAX_V;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      value_q <= value_nxt;
      rem_q   <= rem_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // Without the range check, an out-of-range start is loaded as max_value instead.
  always_comb begin
    in_range = (start_value >= MIN_V) && (start_value <= MAX_V);
    reject   = RANGE_CHECK && !in_range;
    fire     = (state == STATE_RUN) && data_ready;
  end

  always_comb begin
    state_nxt = state;
    value_nxt = value_q;
    rem_nxt   = rem_q;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    case (state)
      STATE_IDLE: begin
        if (start) begin
          if (reject) begin
            err_nxt  = 1'b1;
            done_nxt = 1'b1;
          end else if (run_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = STATE_RUN;
            value_nxt = in_range ? start_value : MAX_V;
            rem_nxt   = run_len;
          end
        end
      end
      STATE_RUN: begin
        if (fire) begin
          if (rem_q == ONE_LEN) begin
            state_nxt = STATE_IDLE;
            rem_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            value_nxt = value_dec;
            rem_nxt   = rem_q - ONE_LEN;
          end
        end
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == STATE_RUN);
    data_valid = (state == STATE_RUN);
    data_out   = value_q;
    remaining  = rem_q;
    done       = done_q;
    error      = err_q;
  end

endmodule

// File: tb/tb_c_decr_seq.sv
// Self-checking bench for c_decr_seq: vector table, hand-written corner sequences, random run vs queue model.
module tb_c_decr_seq;

  localparam int MINV = 4;
  localparam int MAXV = 7;
  localparam int R    = MAXV - MINV + 1;
`ifdef C_DECR_SEQ_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] start_value = '0;
  logic [3:0] run_len = '0;
  logic       busy, data_valid, data_ready, done, error;
  logic [3:0] data_out, remaining;

  initial data_ready = 1'b0;

  c_decr_seq #(
    .width    (4),
    .min_value(MINV),
    .max_value(MAXV),
    .len_width(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_value(start_value),
    .run_len    (run_len),
    .busy       (busy),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .remaining  (remaining),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the pending run is a queue of values computed by modular arithmetic.
  bit m_busy, m_done, m_err;
  int m_out;
  int m_q[$];

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_out = MAXV;
    m_q.delete();
  endfunction

  function automatic void model_step(bit s, int sv, int len, bit r);
    bit ok;
    int first;
    m_done = 0;
    if (m_busy) begin
      if (r) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_out = m_q[0];
        end
      end
    end else if (s) begin
      ok = (sv >= MINV) && (sv <= MAXV);
      if (RC && !ok) begin
        m_err = 1;
        m_done = 1;
      end else if (len == 0) begin
        m_done = 1;
      end else begin
        first = ok ? sv : MAXV;
        for (int k = 0; k < len; k++)
          m_q.push_back(MINV + ((first - MINV - (k % R)) + R) % R);
        m_busy = 1;
        m_out = m_q[0];
      end
    end
  endfunction

  function automatic void compare_model(string tag);
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".valid"}, data_valid, m_busy);
    check({tag, ".data_out"}, data_out, m_out);
    check({tag, ".remaining"}, remaining, m_q.size());
    check({tag, ".done"}, done, m_done);
    check({tag, ".error"}, error, m_err);
  endfunction

  task automatic cycle(input bit s, input int sv, input int len, input bit r, input bit use_model);
    start = s; start_value = 4'(sv); run_len = 4'(len); data_ready = r;
    @(posedge clk);
    model_step(s, sv, len, r);
    #1;
    if (use_model) compare_model("model");
  endtask

  typedef struct {
    bit s; int sv; int len; bit rdy;
    bit busy; int out; int rem; bit done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit s, int sv, int len, bit rdy, bit b, int o, int rm, bit d);
    vec_t v;
    v.s = s; v.sv = sv; v.len = len; v.rdy = rdy;
    v.busy = b; v.out = o; v.rem = rm; v.done = d;
    vecs.push_back(v);
  endfunction

  int wrap_exp[9];

  initial begin
    model_reset();
    // start(6,5), ready high: 6,5,4,7,6 then done
    add(1, 6, 5, 1, 1, 6, 5, 0);
    add(0, 0, 0, 1, 1, 5, 4, 0);
    add(0, 0, 0, 1, 1, 4, 3, 0);
    add(0, 0, 0, 1, 1, 7, 2, 0);
    add(0, 0, 0, 1, 1, 6, 1, 0);
    add(0, 0, 0, 1, 0, 6, 0, 1);
    add(0, 0, 0, 1, 0, 6, 0, 0);
    // backpressure: start(5,3)
    add(1, 5, 3, 0, 1, 5, 3, 0);
    add(0, 0, 0, 0, 1, 5, 3, 0);
    add(0, 0, 0, 1, 1, 4, 2, 0);
    add(0, 0, 0, 0, 1, 4, 2, 0);
    add(0, 0, 0, 1, 1, 7, 1, 0);
    add(0, 0, 0, 1, 0, 7, 0, 1);
    add(0, 0, 0, 0, 0, 7, 0, 0);
    // run_len = 0
    add(1, 5, 0, 1, 0, 7, 0, 1);
    add(0, 0, 0, 1, 0, 7, 0, 0);
    // start during RUN is ignored
    add(1, 7, 3, 1, 1, 7, 3, 0);
    add(1, 5, 9, 1, 1, 6, 2, 0);
    add(1, 4, 2, 1, 1, 5, 1, 0);
    add(0, 0, 0, 1, 0, 5, 0, 1);
    add(0, 0, 0, 0, 0, 5, 0, 0);

    // reset state
    #12;
    check("rst.busy", busy, 0);
    check("rst.valid", data_valid, 0);
    check("rst.data_out", data_out, MAXV);
    check("rst.remaining", remaining, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].s, vecs[i].sv, vecs[i].len, vecs[i].rdy, 0);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d.valid", i), data_valid, vecs[i].busy);
      check($sformatf("vec%0d.data_out", i), data_out, vecs[i].out);
      check($sformatf("vec%0d.remaining", i), remaining, vecs[i].rem);
      check($sformatf("vec%0d.done", i), done, vecs[i].done);
    end

    // wrap: run_len=9 from 7
    wrap_exp = '{7, 6, 5, 4, 7, 6, 5, 4, 7};
    cycle(1, 7, 9, 0, 1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("wrap%0d.data_out", i), data_out, wrap_exp[i]);
      check($sformatf("wrap%0d.remaining", i), remaining, 9 - i);
      cycle(0, 0, 0, 1, 1);
    end
    check("wrap.done", done, 1);

    // out-of-range start(2,3)
    cycle(1, 2, 3, 1, 1);
    check("oor.error", error, RC ? 1 : 0);
    check("oor.valid", data_valid, RC ? 0 : 1);
    check("oor.done", done, RC ? 1 : 0);
    check("oor.data_out", data_out, MAXV);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    check("oor.error_hold", error, RC ? 1 : 0);

    // reset mid-run after first accepted value
    cycle(1, 7, 3, 1, 1);
    cycle(0, 0, 0, 1, 1);
    check("midrst.pre_data_out", data_out, 6);
    #2 reset = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.valid", data_valid, 0);
    check("midrst.data_out", data_out, MAXV);
    check("midrst.remaining", remaining, 0);
    check("midrst.done", done, 0);
    check("midrst.error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);

    // random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      bit s, r;
      int sv, len;
      s   = ($urandom_range(0, 2) == 0);
      sv  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(MINV, MAXV));
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      r   = ($urandom_range(0, 9) < 7);
      cycle(s, sv, len, r, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/c_decr_seq.md
Name: c_decr_seq

Overview:
- Sequential counterpart of the wrapping incrementer: emits a run of values in descending order over the closed range [min_value, max_value].
- Wraps from min_value to max_value.
- Values are delivered through a valid/ready handshake.
- Used by the router for reverse-order slot walks, e.g. draining buffer slots newest-first and returning credits in reverse allocation order.

Parameters:
- width, 4, bit width of emitted values and of start_value.
- min_value, 4, lowest legal value in the range.
- max_value, 7, highest legal value; must satisfy min_value <= max_value < 2^width.
- len_width, 4, bit width of the run-length input.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a new run; sampled only in IDLE.
- start_value  input  width  first value emitted in the run.
- run_len  input  len_width  number of values to emit; 0 means no values.
- busy  output  1  high while in RUN.
- data_valid  output  1  data_out holds a valid value.
- data_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  width  current value.
- remaining  output  len_width  values still to be emitted, including the current one.
- done  output  1  one-cycle pulse when a run completes.
- error  output  1  range error flag; see Optional Feature.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, busy=0, data_valid=0, data_out=max_value, remaining=0, done=0, error=0. Reset asserted mid-run aborts the run immediately. No done pulse is produced for an aborted run.
- The value register is reset to max_value, not 0, so it always holds an in-range value.
- Decrement rule: next = (cur == min_value) ? max_value : cur-1. Computed at width bits, never leaves the range.
- IDLE:
  - start=1 and run_len!=0: next cycle state=RUN, data_out=start_value, remaining=run_len, data_valid=1, busy=1.
  - start=1 and run_len==0: stay IDLE, pulse done next cycle, no values emitted.
  - start=0: hold.
- RUN:
  - Handshake fires when data_valid & data_ready.
  - On fire with remaining>1: data_out<=next, remaining<=remaining-1, data_valid stays 1.
  - On fire with remaining==1: state<=IDLE, data_valid<=0, busy<=0, remaining<=0, done<=1 for one cycle. data_out holds the last value.
  - No fire: all outputs hold; data_out must be stable while valid and not ready.
  - start is ignored in RUN; there is no queuing.
- Latency: first value is valid 1 cycle after start. Then up to one value per cycle under continuous ready. A run of N values takes N+1 cycles from start to the done pulse.
- Runs longer than the range size wrap repeatedly; e.g. with range 4..7, run_len=9 from 7 gives 7,6,5,4,7,6,5,4,7.
- data_ready while data_valid=0 has no effect.

Optional Feature:
- Macro: C_DECR_SEQ_RANGE_CHECK_EN.
- Defined:
  - start_value outside [min_value, max_value] in IDLE with start=1 rejects the run: state stays IDLE, error<=1 (sticky until reset), done pulses next cycle.
  - A valid start does not clear error.
- Undefined:
  - error tied 0.
  - Out-of-range start_value is replaced by max_value when loaded.

Decomposition:
- Shared package holds:
  - state encoding constants: STATE_IDLE=1'b0, STATE_RUN=1'b1;
  - the state width constant.
- Natural sub-module: c_decr, a combinational wrapping decrementer with the same width/min_value/max_value parameters as c_incr. It is instantiated once for the next-value path and is reusable elsewhere.
- The FSM, counters and handshake stay in c_decr_seq.

Test Plan (width=4, min=4, max=7, len_width=4):
- Reset mid-run: after start(7,3), assert reset after first value -> busy=0, data_valid=0, data_out=7, remaining=0, no done pulse.
- start(6,5), ready held high -> data_out 6,5,4,7,6 on consecutive cycles; remaining 5..1; done pulses the cycle after the 5th accept.
- Backpressure: start(5,3), ready pattern 0,0,1,0,1,1 -> data_out holds 5 for two cycles, then 4, holds, then 3 is never produced; output order 5,4,7, then done.
- start with run_len=0 -> no data_valid, done pulses once, busy stays 0.
- start pulsed during RUN with different start_value -> ignored; the current sequence continues unchanged.
- Macro defined, start(2,3) -> error=1, no data_valid, done pulse. Macro undefined, start(2,3) -> emits 7,6,5 and error=0.
